// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, 0.01 s prescaler and 4-digit BCD count 00.00..99.99.
// Optional lap freeze compiled in with STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_stop_i,
    input  logic       set_zero_i,
    input  logic       lap_i,
    output logic [3:0] hund_o,
    output logic [3:0] tenth_o,
    output logic [3:0] sec_o,
    output logic [3:0] tens_o,
    output logic       running_o,
    output logic       lap_active_o,
    output logic       wrap_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [23:0] PRESC_MAX = 24'(TICK_DIV - 1);

    state_t          r_state, w_state_nx;
    logic [23:0]     r_presc, w_presc_nx;
    logic [3:0][3:0] r_cnt, w_cnt_nx;   // [0] = hundredths ... [3] = tens of seconds
    logic            r_wrap, w_wrap_nx;
    logic            r_running;
    logic            w_tick;
    logic            w_carry;
    logic            w_clear;

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_cnt_nx   = r_cnt;
        w_wrap_nx  = 1'b0;
        w_carry    = 1'b0;
        w_tick     = (r_state == S_RUN) && (r_presc == PRESC_MAX);
        w_clear    = (r_state == S_PAUSE) && set_zero_i;

        case (r_state)
            S_IDLE:  if (start_stop_i) w_state_nx = S_RUN;
            S_RUN:   if (start_stop_i) w_state_nx = S_PAUSE;
            S_PAUSE: begin
                if (set_zero_i)        w_state_nx = S_IDLE;
                else if (start_stop_i) w_state_nx = S_RUN;
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (r_state == S_RUN)
            w_presc_nx = w_tick ? 24'd0 : r_presc + 24'd1;

        // BCD ripple; a carry out of the top digit is the 99.99 rollover
        if (w_tick) begin
            w_carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (w_carry) begin
                    if (r_cnt[i] == 4'd9) begin
                        w_cnt_nx[i] = 4'd0;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + 4'd1;
                        w_carry     = 1'b0;
                    end
                end
            end
            w_wrap_nx = w_carry;
        end

        if (w_clear) begin
            w_presc_nx = 24'd0;
            w_cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_presc   <= 24'd0;
            r_cnt     <= '0;
            r_wrap    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_presc   <= w_presc_nx;
            r_cnt     <= w_cnt_nx;
            r_wrap    <= w_wrap_nx;
            r_running <= (w_state_nx == S_RUN);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [3:0][3:0] r_hold, w_hold_nx;
    logic [3:0][3:0] r_disp, w_disp_nx;
    logic            r_lap, w_lap_nx;

    always_comb begin
        w_lap_nx  = r_lap;
        w_hold_nx = r_hold;
        if (lap_i) begin
            if ((r_state == S_RUN) && !r_lap) begin
                w_lap_nx  = 1'b1;
                w_hold_nx = r_cnt;
            end else if (r_lap && (r_state != S_IDLE)) begin
                w_lap_nx = 1'b0;
            end
        end
        if (w_clear) w_lap_nx = 1'b0;
        w_disp_nx = w_lap_nx ? w_hold_nx : w_cnt_nx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lap  <= 1'b0;
            r_hold <= '0;
            r_disp <= '0;
        end else begin
            r_lap  <= w_lap_nx;
            r_hold <= w_hold_nx;
            r_disp <= w_disp_nx;
        end
    end

    assign {tens_o, sec_o, tenth_o, hund_o} = r_disp;
    assign lap_active_o = r_lap;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap_i;
    assign {tens_o, sec_o, tenth_o, hund_o} = r_cnt;
    assign lap_active_o = 1'b0;
`endif

    assign running_o = r_running;
    assign wrap_o    = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: integer-hundredths reference model, random and directed presses.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, ss, sz, lp;
    logic [3:0] hund, tenth, sec, tens;
    logic       running, lap_active, wrap;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk_i(clk), .rst_i(rst), .start_stop_i(ss), .set_zero_i(sz), .lap_i(lp),
        .hund_o(hund), .tenth_o(tenth), .sec_o(sec), .tens_o(tens),
        .running_o(running), .lap_active_o(lap_active), .wrap_o(wrap)
    );

    typedef struct {
        int disp;
        bit run;
        bit lap;
        bit wrp;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    int dut_wraps = 0, exp_wraps = 0;

    // reference model: time kept as integer hundredths of a second
    int m_st = 0;  // 0 idle, 1 run, 2 pause
    int m_pre = 0, m_t = 0, m_hold = 0;
    bit m_lap = 0, m_wrap = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic step(input bit s, input bit z, input bit l, input bit r);
        exp_t e;
        int st_old, t_old;
        bit lap_old;
        ss = s; sz = z; lp = l; rst = r;
        if (r) begin
            m_st = 0; m_pre = 0; m_t = 0; m_hold = 0; m_lap = 0; m_wrap = 0;
        end else begin
            st_old = m_st; t_old = m_t; lap_old = m_lap;
            m_wrap = 0;
            if (st_old == 1) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_t = m_t + 1;
                    if (m_t == 10000) begin m_t = 0; m_wrap = 1; exp_wraps++; end
                end else m_pre = m_pre + 1;
            end
            if (LAP && l) begin
                if (st_old == 1 && !lap_old) begin m_lap = 1; m_hold = t_old; end
                else if (lap_old && st_old != 0) m_lap = 0;
            end
            case (st_old)
                0: if (s) m_st = 1;
                1: if (s) m_st = 2;
                default: begin
                    if (z) begin m_st = 0; m_pre = 0; m_t = 0; m_lap = 0; end
                    else if (s) m_st = 1;
                end
            endcase
        end
        e.disp = m_lap ? m_hold : m_t;
        e.run  = (m_st == 1);
        e.lap  = m_lap;
        e.wrp  = m_wrap;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (wrap === 1'b1) dut_wraps++;
            chk("digits", int'({tens, sec, tenth, hund}), int'(to_bcd(e.disp)));
            chk("running", int'(running), int'(e.run));
            chk("lap_active", int'(lap_active), int'(e.lap));
            chk("wrap", int'(wrap), int'(e.wrp));
        end
    end

    initial begin
        ss = 0; sz = 0; lp = 0; rst = 1;
        @(posedge clk); #1;
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);              // reset beats every press
        idle(2);
        step(1, 0, 0, 0);              // start: first tick TD cycles later
        idle(6);
        step(1, 0, 0, 0);              // pause mid-prescale
        idle(50);
        step(1, 0, 0, 0);              // resume
        idle(9);
        step(0, 1, 0, 0);              // set_zero in RUN ignored
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);              // lap in PAUSE with no freeze ignored
        step(1, 1, 0, 0);              // both in PAUSE: clear wins
        idle(3);
        step(0, 0, 1, 0);              // lap in IDLE ignored
        step(1, 0, 0, 0);
        idle(4 * TD - 1);
        step(0, 0, 1, 0);              // freeze
        idle(20);
        step(0, 0, 1, 0);              // release
        idle(5);
        step(0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 1);              // reset mid-RUN with freeze active
        idle(2);
        step(1, 0, 0, 0);              // run through 99.99 rollover
        repeat (10000 * TD + 20) step(0, 0, 0, 0);
        repeat (4000) step($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
        step(0, 0, 0, 1);
        idle(2);
        @(posedge clk); #1;
        chk("wrap_count", dut_wraps, exp_wraps);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk_i cycles per 0.01 s count step; legal range 2..2^24.
REQ-002 clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_stop_i  input  1  one-cycle press pulse from the upstream debounce press output; toggles run/pause.
REQ-005 set_zero_i  input  1  one-cycle press pulse; clears the count.
REQ-006 lap_i  input  1  one-cycle press pulse; toggles the lap freeze.
REQ-007 hund_o, tenth_o, sec_o, tens_o  output  4 each  BCD digits of the displayed time, range 00.00..99.99.
REQ-008 running_o  output  1  high while in state RUN.
REQ-009 lap_active_o  output  1  high while the display is frozen.
REQ-010 wrap_o  output  1  one-cycle pulse on rollover from 99.99 to 00.00.

Function
REQ-011 States: IDLE (count zero, stopped), RUN, PAUSE; state encoding is registered.
REQ-012 IDLE + start_stop_i -> RUN; RUN + start_stop_i -> PAUSE; PAUSE + start_stop_i -> RUN.
REQ-013 PAUSE + set_zero_i -> IDLE, clearing digits, prescaler and lap freeze on that edge.
REQ-014 set_zero_i in RUN or IDLE has no effect.
REQ-015 start_stop_i and set_zero_i in the same cycle in PAUSE: set_zero_i wins, next state IDLE.
REQ-016 Prescaler, 24 bits, counts 0..TICK_DIV-1 only in RUN, holds its value in PAUSE and is zero in IDLE.
REQ-017 Tick: prescaler equal to TICK_DIV-1 in RUN; on that edge the prescaler returns to 0 and the count increments by 0.01 s.
REQ-018 Increment is BCD cascade: hund 9->0 carries to tenth, tenth 9->0 to sec, sec 9->0 to tens; no digit ever exceeds 9.
REQ-019 99.99 + tick -> 00.00 on the same edge, wrap_o high for exactly that following cycle; counting continues.
REQ-020 First tick after IDLE->RUN occurs exactly TICK_DIV cycles after the start_stop_i edge.
REQ-021 Digit outputs and running_o are registered; they change on the edge that performs the update, with no added latency.
REQ-022 Pulse inputs held high for multiple cycles act once per cycle high; the upstream stage guarantees one-cycle pulses.

Reset
REQ-023 rst_i high at a rising edge: state IDLE, prescaler 0, all digits 0, running_o 0, lap_active_o 0, wrap_o 0.
REQ-024 rst_i overrides every other input in the same cycle, including mid-RUN and mid-lap.
REQ-025 No output is X after the first edge with rst_i high.

Configuration
REQ-026 Macro STOPWATCH_LAP_EN compiles in the lap feature.
REQ-027 With STOPWATCH_LAP_EN: lap_i in RUN with lap_active_o 0 captures the current count into a hold register and sets lap_active_o; digit outputs show the hold value while counting continues internally.
REQ-028 With STOPWATCH_LAP_EN: lap_i with lap_active_o 1, in RUN or PAUSE, clears lap_active_o; outputs show the live count on the next cycle.
REQ-029 With STOPWATCH_LAP_EN: lap_i in IDLE, and lap_i with lap_active_o 0 in PAUSE, are ignored.
REQ-030 Without STOPWATCH_LAP_EN: the lap_i port remains, is ignored, and lap_active_o is tied 0; no hold register is synthesized.

Verification
REQ-031 TICK_DIV=4, reset, start_stop_i pulse -> hund_o=1 exactly 4 cycles later and running_o=1 throughout.
REQ-032 TICK_DIV=2, preload by running to 99.99 -> next tick gives all digits 0 and a single-cycle wrap_o=1.
REQ-033 TICK_DIV=10, run, pause at prescaler 6, wait 50 cycles, resume -> next tick 4 cycles after resume.
REQ-034 PAUSE with start_stop_i and set_zero_i in the same cycle -> IDLE, digits 00.00, running_o=0.
REQ-035 With STOPWATCH_LAP_EN, TICK_DIV=2: lap_i at 00.05 -> outputs hold 00.05 for 20 cycles; second lap_i -> outputs show 00.15.
REQ-036 rst_i asserted during RUN with lap_active_o=1 -> all outputs 0 and state IDLE on the next edge.
